// File: rtl/tdm_demux.sv
// Time-division 1-to-N demultiplexer: steers one word per valid cycle
// into a registered per-channel output, aligned to a start-of-frame marker.
module tdm_demux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      in_sof,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_valid,
    output logic                      frame_done,
    output logic                      sync_err,
    output logic                      locked
);

    localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [SW-1:0] LAST = SW'(CHANNELS - 1);

    typedef enum logic {HUNT, RUN} state_t;

    state_t                    state_q, state_d;
    logic [SW-1:0]             slot_q, slot_d;
    logic [CHANNELS*WIDTH-1:0] data_q, data_d;
    logic [CHANNELS-1:0]       valid_q, valid_d;
    logic                      frame_done_q, frame_done_d;
    logic                      sync_err_q, sync_err_d;

    logic                      wr_en;
    logic [SW-1:0]             wr_slot;
    logic                      wr_last;
    logic                      wr_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= HUNT;
            slot_q       <= '0;
            data_q       <= '0;
            valid_q      <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    // An sof always restarts at slot 0; it is only an error mid-frame.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        wr_en   = 1'b0;
        wr_slot = slot_q;
        wr_last = 1'b0;
        wr_err  = 1'b0;
        if (in_valid) begin
            if (in_sof) begin
                wr_en   = 1'b1;
                wr_slot = '0;
                slot_d  = SW'(1);
                state_d = RUN;
                wr_err  = (state_q == RUN) && (slot_q != '0);
            end else if (state_q == RUN) begin
                wr_en   = 1'b1;
                wr_slot = slot_q;
                wr_last = (slot_q == LAST);
                slot_d  = wr_last ? '0 : slot_q + SW'(1);
            end
        end
    end

    always_comb begin
        data_d       = data_q;
        valid_d      = '0;
        frame_done_d = wr_last;
        sync_err_d   = wr_err;
        for (int k = 0; k < CHANNELS; k++) begin
            if (wr_en && (wr_slot == SW'(k))) begin
                data_d[k*WIDTH +: WIDTH] = in_data;
                valid_d[k]               = 1'b1;
            end
        end
    end

    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;
    assign locked     = (state_q == RUN);

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux with WIDTH=8, CHANNELS=4.
module tb_tdm_demux;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_sof;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic        frame_done;
    logic        sync_err;
    logic        locked;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fd1 = 0;
    int fd2 = 0;

    tdm_demux #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_sof(in_sof),
        .out_data(out_data),
        .out_valid(out_valid),
        .frame_done(frame_done),
        .sync_err(sync_err),
        .locked(locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one word for one cycle, then sample 1 time unit after the edge.
    task automatic step(input logic v, input logic s, input logic [7:0] d);
        @(negedge clk);
        in_valid = v;
        in_sof   = s;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic pulses(input string tag, input logic [3:0] v, input logic fd, input logic se);
        check({tag, ".valid"}, {28'd0, out_valid}, {28'd0, v});
        check({tag, ".fd"}, {31'd0, frame_done}, {31'd0, fd});
        check({tag, ".se"}, {31'd0, sync_err}, {31'd0, se});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst.data", out_data, 32'h0);
        check("rst.locked", {31'd0, locked}, 32'd0);
        pulses("rst", 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("init.data", out_data, 32'h0);
        check("init.locked", {31'd0, locked}, 32'd0);
        pulses("init", 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Basic aligned frame
        step(1, 1, 8'hA0);
        pulses("t1.w0", 4'b0001, 0, 0);
        check("t1.locked", {31'd0, locked}, 32'd1);
        step(1, 0, 8'hA1);
        pulses("t1.w1", 4'b0010, 0, 0);
        step(1, 0, 8'hA2);
        pulses("t1.w2", 4'b0100, 0, 0);
        step(1, 0, 8'hA3);
        pulses("t1.w3", 4'b1000, 1, 0);
        check("t1.data", out_data, 32'hA3A2A1A0);
        step(0, 0, 8'hFF);
        pulses("t1.idle", 4'b0000, 0, 0);
        check("t1.hold", out_data, 32'hA3A2A1A0);

        // Words in HUNT are dropped until sof
        do_reset();
        step(1, 0, 8'h11);
        pulses("t2.d0", 4'b0000, 0, 0);
        step(1, 0, 8'h22);
        pulses("t2.d1", 4'b0000, 0, 0);
        step(1, 0, 8'h33);
        pulses("t2.d2", 4'b0000, 0, 0);
        check("t2.dropped", out_data, 32'h0);
        check("t2.unlocked", {31'd0, locked}, 32'd0);
        step(0, 1, 8'hEE);
        pulses("t2.sofnov", 4'b0000, 0, 0);
        check("t2.sofnov.lk", {31'd0, locked}, 32'd0);
        step(1, 1, 8'h44);
        pulses("t2.sof", 4'b0001, 0, 0);
        check("t2.data", out_data, 32'h00000044);
        check("t2.locked", {31'd0, locked}, 32'd1);

        // Unexpected sof at slot 2
        step(1, 0, 8'h66);
        check("t3.pre", out_data, 32'h00006644);
        step(1, 1, 8'h55);
        pulses("t3.err", 4'b0001, 0, 1);
        check("t3.data", out_data, 32'h00006655);
        step(1, 0, 8'h77);
        pulses("t3.next", 4'b0010, 0, 0);
        check("t3.data1", out_data, 32'h00007755);
        step(1, 0, 8'h88);
        pulses("t3.s2", 4'b0100, 0, 0);
        step(1, 0, 8'h99);
        pulses("t3.s3", 4'b1000, 1, 0);
        check("t3.data3", out_data, 32'h99887755);

        // Frame with 3-cycle gaps between words
        step(1, 1, 8'hA0);
        pulses("t4.w0", 4'b0001, 0, 0);
        for (int w = 1; w < 4; w++) begin
            for (int g = 0; g < 3; g++) begin
                step(0, 0, 8'h5A);
                pulses("t4.gap", 4'b0000, 0, 0);
            end
            step(1, 0, 8'hA0 + 8'(w));
        end
        pulses("t4.w3", 4'b1000, 1, 0);
        check("t4.data", out_data, 32'hA3A2A1A0);
        check("t4.locked", {31'd0, locked}, 32'd1);

        // Reset mid-frame
        step(1, 1, 8'hC0);
        step(1, 0, 8'hC1);
        check("t5.pre", out_data, 32'hA3A2C1C0);
        do_reset();
        step(1, 0, 8'hD1);
        pulses("t5.drop", 4'b0000, 0, 0);
        check("t5.drop.data", out_data, 32'h0);
        check("t5.drop.lk", {31'd0, locked}, 32'd0);
        step(1, 1, 8'hD0);
        check("t5.relock", out_data, 32'h000000D0);
        check("t5.locked", {31'd0, locked}, 32'd1);
        step(1, 0, 8'hD1);
        step(1, 0, 8'hD2);
        step(1, 0, 8'hD3);
        pulses("t5.end", 4'b1000, 1, 0);
        check("t5.data", out_data, 32'hD3D2D1D0);

        // Back-to-back frames
        step(1, 1, 8'h01);
        pulses("t6.f1w0", 4'b0001, 0, 0);
        step(1, 0, 8'h02);
        step(1, 0, 8'h03);
        step(1, 0, 8'h04);
        pulses("t6.f1w3", 4'b1000, 1, 0);
        fd1 = cyc;
        step(1, 1, 8'h05);
        pulses("t6.f2w0", 4'b0001, 0, 0);
        step(1, 0, 8'h06);
        step(1, 0, 8'h07);
        step(1, 0, 8'h08);
        pulses("t6.f2w3", 4'b1000, 1, 0);
        fd2 = cyc;
        check("t6.spacing", 32'(fd2 - fd1), 32'd4);
        check("t6.data", out_data, 32'h08070605);
        step(0, 0, 8'h00);
        pulses("t6.idle", 4'b0000, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
